hilo_ctrl: RTL and testbench
============================

// Module: hilo_ctrl
// PURPOSE
//   Consumer side of the multiply/divide datapath: sequences MULT/MULTU/DIV/DIVU, waits out
//   the datapath latency, captures its hi/lo result into architectural HI/LO registers, and
//   serves MFHI/MFLO/MTHI/MTLO for the CPU54 pipeline. Sits between ID/EX control and the
//   mul/div unit. Raises a pipeline stall while a result is pending.
// PARAMETERS
//   MUL_LAT  32  cycles from op accept to result capture for MULT/MULTU (>=1)
//   DIV_LAT  32  cycles from op accept to result capture for DIV/DIVU (>=1)
//   CNT_W    6   width of latency counter; must hold max(MUL_LAT,DIV_LAT)
// PORTS
//   clk        in   1   rising-edge clock
//   rst        in   1   synchronous reset, active-high
//   op_valid   in   1   issue mul/div op this cycle
//   op_code    in   2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   div_zero   in   1   divisor (rt) == 0, sampled with op_valid
//   md_hi      in   32  hi result from mul/div datapath
//   md_lo      in   32  lo result from mul/div datapath
//   md_sel     out  2   op_code held for datapath select while busy
//   md_en      out  1   datapath enable (1 while BUSY)
//   mthi       in   1   write wdata to HI
//   mtlo       in   1   write wdata to LO
//   wdata      in   32  rs value for MTHI/MTLO
//   mfhi       in   1   read HI
//   mflo       in   1   read LO
//   rdata      out  32  registered read data for MFHI/MFLO
//   hi         out  32  architectural HI
//   lo         out  32  architectural LO
//   stall      out  1   combinational: hold pipeline this cycle
//   done       out  1   1-cycle pulse on result capture
// BEHAVIOUR
//   Reset: hi=lo=rdata=0, md_en=0, md_sel=0, done=0, state=IDLE, counter=0; rst wins over all.
//   FSM: IDLE -> BUSY on op_valid (latch op_code->md_sel, div_zero, counter=LAT-1 by op class).
//        BUSY: counter decrements each cycle; at counter==0 go CAPTURE.
//        CAPTURE (1 cycle): hi<=md_hi, lo<=md_lo, done=1; if latched op DIVU/DIV with
//        div_zero=1, hi/lo unchanged (done still pulses); -> IDLE.
//   Latency: op accepted in cycle N, hi/lo updated at edge ending cycle N+LAT+1.
//   stall = (state!=IDLE) & (op_valid|mfhi|mflo|mthi|mtlo).
//   While stalled: op not accepted, MT writes dropped, rdata held; pipeline re-presents.
//   IDLE reads: mfhi -> rdata<=hi; mflo -> rdata<=lo (1-cycle registered); both set -> HI wins.
//   IDLE writes: mthi/mtlo write on the edge; both set -> both written with wdata.
//   op_valid with mthi/mtlo same IDLE cycle: op accepted, MT write performed too, the capture
//   later overwrites it.
//   mfhi with mthi same IDLE cycle: rdata gets old HI (read-before-write).
//   Reset mid-BUSY: abort, no capture, hi/lo=0.
// CONFIGURATION
//   HILO_BYPASS_EN defined: in CAPTURE, mfhi/mflo not stalled; rdata takes md_hi/md_lo
//   directly (and stall excludes mfhi/mflo in CAPTURE). Undefined: stall covers CAPTURE,
//   read served the next IDLE cycle from hi/lo.
// TESTING
//   MULTU, MUL_LAT=32, md_hi=0x1, md_lo=0xFFFF_FFFE -> done at cycle 33 after accept, hi=0x1, lo=0xFFFF_FFFE.
//   DIVU with div_zero=1, prior hi=0x5 lo=0x7 -> done pulses, hi=0x5, lo=0x7 unchanged.
//   mfhi asserted 3 cycles after DIV accept -> stall=1 until IDLE, then rdata=new hi.
//   mthi=mtlo=1, wdata=0xDEAD_BEEF in IDLE -> hi=lo=0xDEAD_BEEF next cycle, stall=0.
//   rst pulse at BUSY count 10 -> state IDLE, hi=lo=0, no done pulse afterwards.
//   With HILO_BYPASS_EN, mflo in CAPTURE with md_lo=0x1234 -> stall=0, rdata=0x1234 next edge.

Source files
------------

// File: rtl/hilo_ctrl_if.sv
// Bus bundle between the ID/EX pipeline stage (master) and the HI/LO
// controller (slave). It carries the mul/div issue handshake, the datapath
// result/select lines, the MFHI/MFLO/MTHI/MTLO requests and the
// architectural HI/LO view.
interface hilo_ctrl_if;
    logic        op_valid;
    logic [1:0]  op_code;
    logic        div_zero;
    logic [31:0] md_hi;
    logic [31:0] md_lo;
    logic [1:0]  md_sel;
    logic        md_en;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        mfhi;
    logic        mflo;
    logic [31:0] rdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        stall;
    logic        done;

    modport master (
        output op_valid, op_code, div_zero, md_hi, md_lo,
        output mthi, mtlo, wdata, mfhi, mflo,
        input  md_sel, md_en, rdata, hi, lo, stall, done
    );

    modport slave (
        input  op_valid, op_code, div_zero, md_hi, md_lo,
        input  mthi, mtlo, wdata, mfhi, mflo,
        output md_sel, md_en, rdata, hi, lo, stall, done
    );
endinterface

// File: rtl/hilo_ctrl.sv
// HI/LO controller for the CPU54 pipeline: sequences MULT/MULTU/DIV/DIVU on
// the mul/div datapath, waits out its latency, captures the hi/lo result into
// the architectural HI/LO registers and serves MFHI/MFLO/MTHI/MTLO.
// Optional feature macro: HILO_BYPASS_EN -- when defined, MFHI/MFLO issued in
// the CAPTURE cycle are not stalled and read the datapath result directly.
module hilo_ctrl #(
    parameter int MUL_LAT = 32,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 6
) (
    input logic         clk,
    input logic         rst,
    hilo_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       sel_q;
    logic             dz_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [31:0]      rdata_q;
    logic             read_req;
    logic             stall_c;
    logic             accept;

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state decode and pipeline stall: any request arriving while an
    // operation is outstanding must be held and re-presented by the pipeline.
    always_comb begin
        next_state = state;
        stall_c    = 1'b0;
        accept     = 1'b0;
        read_req   = bus.mfhi | bus.mflo;
        case (state)
            IDLE: begin
                accept = bus.op_valid;
                if (bus.op_valid) next_state = BUSY;
            end
            BUSY: begin
                stall_c = bus.op_valid | read_req | bus.mthi | bus.mtlo;
                if (cnt == '0) next_state = CAPTURE;
            end
            CAPTURE: begin
`ifdef HILO_BYPASS_EN
                stall_c = bus.op_valid | bus.mthi | bus.mtlo;
`else
                stall_c = bus.op_valid | read_req | bus.mthi | bus.mtlo;
`endif
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath registers: op latch and latency counter, HI/LO updates from
    // MT writes or result capture, and the registered MF read port. A divide
    // by zero leaves HI/LO untouched but still completes normally.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            sel_q   <= 2'b00;
            dz_q    <= 1'b0;
            hi_q    <= 32'h0;
            lo_q    <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sel_q <= bus.op_code;
                        dz_q  <= bus.div_zero;
                        cnt   <= bus.op_code[1] ? CNT_W'(DIV_LAT - 1)
                                                : CNT_W'(MUL_LAT - 1);
                    end
                    if (bus.mfhi)      rdata_q <= hi_q;
                    else if (bus.mflo) rdata_q <= lo_q;
                    if (bus.mthi) hi_q <= bus.wdata;
                    if (bus.mtlo) lo_q <= bus.wdata;
                end
                BUSY: begin
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                CAPTURE: begin
                    if (!(sel_q[1] && dz_q)) begin
                        hi_q <= bus.md_hi;
                        lo_q <= bus.md_lo;
                    end
`ifdef HILO_BYPASS_EN
                    if (bus.mfhi)      rdata_q <= bus.md_hi;
                    else if (bus.mflo) rdata_q <= bus.md_lo;
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.md_sel = sel_q;
    assign bus.md_en  = (state == BUSY);
    assign bus.done   = (state == CAPTURE);
    assign bus.stall  = stall_c;
    assign bus.hi     = hi_q;
    assign bus.lo     = lo_q;
    assign bus.rdata  = rdata_q;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed testbench for hilo_ctrl with default latencies (32/32).
module tb_hilo_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    hilo_ctrl_if bus ();

    hilo_ctrl #(.MUL_LAT(32), .DIV_LAT(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.op_valid = 1'b0;
        bus.op_code  = 2'b00;
        bus.div_zero = 1'b0;
        bus.mthi     = 1'b0;
        bus.mtlo     = 1'b0;
        bus.mfhi     = 1'b0;
        bus.mflo     = 1'b0;
        bus.wdata    = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++; if (bus.hi !== 32'h0)    begin bad++; $display("[TB] FAIL reset_hi got=%h exp=%h", bus.hi, 32'h0); end
        total++; if (bus.lo !== 32'h0)    begin bad++; $display("[TB] FAIL reset_lo got=%h exp=%h", bus.lo, 32'h0); end
        total++; if (bus.rdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_rdata got=%h exp=%h", bus.rdata, 32'h0); end
        total++; if (bus.md_en !== 1'b0)  begin bad++; $display("[TB] FAIL reset_md_en got=%b exp=0", bus.md_en); end
        total++; if (bus.md_sel !== 2'b00) begin bad++; $display("[TB] FAIL reset_md_sel got=%b exp=00", bus.md_sel); end
        total++; if (bus.done !== 1'b0)   begin bad++; $display("[TB] FAIL reset_done got=%b exp=0", bus.done); end
        rst = 1'b0;
        bus.mfhi = 1'b1;
        #1;
        total++; if (bus.stall !== 1'b0)  begin bad++; $display("[TB] FAIL reset_idle_stall got=%b exp=0", bus.stall); end
        bus.mfhi = 1'b0;
    endtask

    task automatic test_mt_both();
        bus.mthi  = 1'b1;
        bus.mtlo  = 1'b1;
        bus.wdata = 32'hDEAD_BEEF;
        #1;
        total++; if (bus.stall !== 1'b0) begin bad++; $display("[TB] FAIL mt_both_stall got=%b exp=0", bus.stall); end
        tick();
        clear_inputs();
        total++; if (bus.hi !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL mt_both_hi got=%h exp=%h", bus.hi, 32'hDEAD_BEEF); end
        total++; if (bus.lo !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL mt_both_lo got=%h exp=%h", bus.lo, 32'hDEAD_BEEF); end
    endtask

    task automatic test_multu();
        int cyc;
        bus.md_hi    = 32'h0000_0001;
        bus.md_lo    = 32'hFFFF_FFFE;
        bus.op_valid = 1'b1;
        bus.op_code  = 2'b01;
        tick();
        clear_inputs();
        cyc = 1;
        total++; if (bus.md_en !== 1'b1)   begin bad++; $display("[TB] FAIL multu_md_en got=%b exp=1", bus.md_en); end
        total++; if (bus.md_sel !== 2'b01) begin bad++; $display("[TB] FAIL multu_md_sel got=%b exp=01", bus.md_sel); end
        while (bus.done !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        total++; if (cyc !== 33) begin bad++; $display("[TB] FAIL multu_latency got=%0d exp=%0d", cyc, 33); end
        total++; if (bus.hi !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL multu_hi_before got=%h exp=%h", bus.hi, 32'hDEAD_BEEF); end
        tick();
        total++; if (bus.hi !== 32'h0000_0001) begin bad++; $display("[TB] FAIL multu_hi got=%h exp=%h", bus.hi, 32'h1); end
        total++; if (bus.lo !== 32'hFFFF_FFFE) begin bad++; $display("[TB] FAIL multu_lo got=%h exp=%h", bus.lo, 32'hFFFF_FFFE); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("[TB] FAIL multu_done_after got=%b exp=0", bus.done); end
        total++; if (bus.md_en !== 1'b0) begin bad++; $display("[TB] FAIL multu_md_en_after got=%b exp=0", bus.md_en); end
    endtask

    task automatic test_div_zero();
        int cyc;
        bus.mthi  = 1'b1;
        bus.wdata = 32'h5;
        tick();
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b1;
        bus.wdata = 32'h7;
        tick();
        clear_inputs();
        total++; if (bus.hi !== 32'h5) begin bad++; $display("[TB] FAIL mthi_only got=%h exp=%h", bus.hi, 32'h5); end
        total++; if (bus.lo !== 32'h7) begin bad++; $display("[TB] FAIL mtlo_only got=%h exp=%h", bus.lo, 32'h7); end
        bus.md_hi    = 32'h1111_1111;
        bus.md_lo    = 32'h2222_2222;
        bus.op_valid = 1'b1;
        bus.op_code  = 2'b11;
        bus.div_zero = 1'b1;
        tick();
        clear_inputs();
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        total++; if (cyc !== 33) begin bad++; $display("[TB] FAIL divz_latency got=%0d exp=%0d", cyc, 33); end
        tick();
        total++; if (bus.hi !== 32'h5) begin bad++; $display("[TB] FAIL divz_hi got=%h exp=%h", bus.hi, 32'h5); end
        total++; if (bus.lo !== 32'h7) begin bad++; $display("[TB] FAIL divz_lo got=%h exp=%h", bus.lo, 32'h7); end
    endtask

    task automatic test_mfhi_stall();
        int stalled;
        int exp_stalled;
`ifdef HILO_BYPASS_EN
        exp_stalled = 30;
`else
        exp_stalled = 31;
`endif
        bus.mflo = 1'b1;
        tick();
        clear_inputs();
        total++; if (bus.rdata !== 32'h7) begin bad++; $display("[TB] FAIL mflo_read got=%h exp=%h", bus.rdata, 32'h7); end
        bus.md_hi    = 32'hCAFE_0001;
        bus.md_lo    = 32'h0BAD_0002;
        bus.op_valid = 1'b1;
        bus.op_code  = 2'b10;
        tick();
        clear_inputs();
        tick();
        tick();
        bus.mfhi = 1'b1;
        #1;
        total++; if (bus.stall !== 1'b1) begin bad++; $display("[TB] FAIL mfhi_busy_stall got=%b exp=1", bus.stall); end
        stalled = 0;
        while (bus.stall === 1'b1 && stalled < 40) begin
            tick();
            stalled++;
        end
        total++; if (stalled !== exp_stalled) begin bad++; $display("[TB] FAIL mfhi_stall_len got=%0d exp=%0d", stalled, exp_stalled); end
`ifndef HILO_BYPASS_EN
        total++; if (bus.rdata !== 32'h7) begin bad++; $display("[TB] FAIL rdata_held got=%h exp=%h", bus.rdata, 32'h7); end
`endif
        tick();
        clear_inputs();
        total++; if (bus.rdata !== 32'hCAFE_0001) begin bad++; $display("[TB] FAIL mfhi_after got=%h exp=%h", bus.rdata, 32'hCAFE_0001); end
        total++; if (bus.lo !== 32'h0BAD_0002) begin bad++; $display("[TB] FAIL div_lo got=%h exp=%h", bus.lo, 32'h0BAD_0002); end
    endtask

    task automatic test_read_before_write();
        bus.mfhi  = 1'b1;
        bus.mthi  = 1'b1;
        bus.wdata = 32'h1111_2222;
        tick();
        clear_inputs();
        total++; if (bus.rdata !== 32'hCAFE_0001) begin bad++; $display("[TB] FAIL rbw_rdata got=%h exp=%h", bus.rdata, 32'hCAFE_0001); end
        total++; if (bus.hi !== 32'h1111_2222) begin bad++; $display("[TB] FAIL rbw_hi got=%h exp=%h", bus.hi, 32'h1111_2222); end
        bus.mfhi = 1'b1;
        bus.mflo = 1'b1;
        tick();
        clear_inputs();
        total++; if (bus.rdata !== 32'h1111_2222) begin bad++; $display("[TB] FAIL both_read_hi_wins got=%h exp=%h", bus.rdata, 32'h1111_2222); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        bus.md_hi    = 32'h0000_1111;
        bus.md_lo    = 32'h2222_0000;
        bus.op_valid = 1'b1;
        bus.op_code  = 2'b00;
        bus.mthi     = 1'b1;
        bus.wdata    = 32'hAAAA_0000;
        tick();
        clear_inputs();
        total++; if (bus.hi !== 32'hAAAA_0000) begin bad++; $display("[TB] FAIL op_mt_hi got=%h exp=%h", bus.hi, 32'hAAAA_0000); end
        bus.op_valid = 1'b1;
        bus.op_code  = 2'b11;
        bus.mtlo     = 1'b1;
        bus.wdata    = 32'h0000_0055;
        #1;
        total++; if (bus.stall !== 1'b1) begin bad++; $display("[TB] FAIL busy_op_stall got=%b exp=1", bus.stall); end
        tick();
        clear_inputs();
        cyc = 2;
        total++; if (bus.md_sel !== 2'b00) begin bad++; $display("[TB] FAIL busy_op_ignored got=%b exp=00", bus.md_sel); end
        total++; if (bus.lo !== 32'h0BAD_0002) begin bad++; $display("[TB] FAIL busy_mt_dropped got=%h exp=%h", bus.lo, 32'h0BAD_0002); end
        while (bus.done !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        total++; if (cyc !== 33) begin bad++; $display("[TB] FAIL mult_latency got=%0d exp=%0d", cyc, 33); end
`ifdef HILO_BYPASS_EN
        bus.mflo = 1'b1;
        #1;
        total++; if (bus.stall !== 1'b0) begin bad++; $display("[TB] FAIL bypass_stall got=%b exp=0", bus.stall); end
        tick();
        clear_inputs();
        total++; if (bus.rdata !== 32'h2222_0000) begin bad++; $display("[TB] FAIL bypass_rdata got=%h exp=%h", bus.rdata, 32'h2222_0000); end
`else
        bus.mflo = 1'b1;
        #1;
        total++; if (bus.stall !== 1'b1) begin bad++; $display("[TB] FAIL capture_read_stall got=%b exp=1", bus.stall); end
        tick();
        clear_inputs();
`endif
        total++; if (bus.hi !== 32'h0000_1111) begin bad++; $display("[TB] FAIL mult_hi got=%h exp=%h", bus.hi, 32'h0000_1111); end
        total++; if (bus.lo !== 32'h2222_0000) begin bad++; $display("[TB] FAIL mult_lo got=%h exp=%h", bus.lo, 32'h2222_0000); end
    endtask

    task automatic test_reset_mid_busy();
        int pulses;
        bus.md_hi    = 32'h9999_9999;
        bus.md_lo    = 32'h8888_8888;
        bus.op_valid = 1'b1;
        bus.op_code  = 2'b01;
        tick();
        clear_inputs();
        for (int i = 0; i < 21; i++) tick();
        total++; if (bus.md_en !== 1'b1) begin bad++; $display("[TB] FAIL mid_busy_md_en got=%b exp=1", bus.md_en); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (bus.hi !== 32'h0) begin bad++; $display("[TB] FAIL abort_hi got=%h exp=%h", bus.hi, 32'h0); end
        total++; if (bus.lo !== 32'h0) begin bad++; $display("[TB] FAIL abort_lo got=%h exp=%h", bus.lo, 32'h0); end
        total++; if (bus.md_en !== 1'b0) begin bad++; $display("[TB] FAIL abort_md_en got=%b exp=0", bus.md_en); end
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1) pulses++;
            tick();
        end
        total++; if (pulses !== 0) begin bad++; $display("[TB] FAIL abort_no_done got=%0d exp=0", pulses); end
        total++; if (bus.hi !== 32'h0) begin bad++; $display("[TB] FAIL abort_hi_late got=%h exp=%h", bus.hi, 32'h0); end
    endtask

    initial begin
        clear_inputs();
        bus.md_hi = 32'h0;
        bus.md_lo = 32'h0;
        #1;
        test_reset();
        test_mt_both();
        test_multu();
        test_div_zero();
        test_mfhi_stall();
        test_read_before_write();
        test_back_to_back();
        test_reset_mid_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
